// File: rtl/sram_ctrl_if.sv
// Host-side request/completion bus of the asynchronous SRAM controller.
// The controller takes the slave modport, the host the master modport.
interface sram_ctrl_if #(
    parameter int AWID = 16,
    parameter int DWID = 8
);
    logic            req;
    logic            wr;
    logic [AWID-1:0] addr;
    logic [DWID-1:0] wdata;
    logic [DWID-1:0] rdata;
    logic            ack;
    logic            busy;

    modport master (
        output req, wr, addr, wdata,
        input  rdata, ack, busy
    );

    modport slave (
        input  req, wr, addr, wdata,
        output rdata, ack, busy
    );
endinterface

// File: rtl/sram_ctrl.sv
// Single-access asynchronous SRAM controller: IDLE -> SETUP -> ACCESS (WAIT+1) -> HOLD.
// Every strobe, ack and busy is a flop loaded from the next-state decode, so pins never glitch.
module sram_ctrl #(
    parameter int AWID = 16,
    parameter int DWID = 8,
    parameter int WAIT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    sram_ctrl_if.slave      bus,
    output logic [AWID-1:0] sram_addr,
    inout  wire  [DWID-1:0] sram_data,
    output logic            sram_ce_n,
    output logic            sram_oe_n,
    output logic            sram_we_n
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] HOLD   = 2'd3;

    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic [3:0]      cnt;
    logic            wr_q;
    logic [DWID-1:0] wdata_q;
    logic [DWID-1:0] rdata_q;
    logic            ack_q;
    logic            busy_q;
    logic            drive;

    logic            accept;
    logic            last_access;
    logic            op_wr;
    logic            ce_n_nxt;
    logic            oe_n_nxt;
    logic            we_n_nxt;
    logic            drive_nxt;

    assign accept      = (state == IDLE) && bus.req;
    assign last_access = (state == ACCESS) && (cnt == WAIT_CNT);
    // On the accepting edge the latched type is not yet valid, so look at the bus directly.
    assign op_wr       = (state == IDLE) ? bus.wr : wr_q;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.req) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (cnt == WAIT_CNT) state_nxt = HOLD;
            HOLD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // oe_n and we_n are decoded from mutually exclusive op_wr terms, so they can never overlap.
    always_comb begin
        ce_n_nxt  = (state_nxt == IDLE);
        oe_n_nxt  = 1'b1;
        we_n_nxt  = 1'b1;
        drive_nxt = 1'b0;
        if (state_nxt != IDLE) begin
            drive_nxt = op_wr;
        end
        if (!op_wr && ((state_nxt == SETUP) || (state_nxt == ACCESS))) begin
            oe_n_nxt = 1'b0;
        end
        if (op_wr && (state_nxt == ACCESS)) begin
            we_n_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            wr_q      <= 1'b0;
            sram_addr <= '0;
            rdata_q   <= '0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            drive     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == SETUP) begin
                cnt <= 4'd0;
            end else if ((state == ACCESS) && !last_access) begin
                cnt <= cnt + 4'd1;
            end
            if (accept) begin
                wr_q      <= bus.wr;
                sram_addr <= bus.addr;
            end
            // Sampled while oe_n is still low; it rises on this same edge.
            if (last_access && !wr_q) begin
                rdata_q <= sram_data;
            end
            ack_q     <= (state_nxt == HOLD);
            busy_q    <= (state_nxt != IDLE);
            sram_ce_n <= ce_n_nxt;
            sram_oe_n <= oe_n_nxt;
            sram_we_n <= we_n_nxt;
            drive     <= drive_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            wdata_q <= bus.wdata;
        end
    end

    assign sram_data = drive ? wdata_q : {DWID{1'bz}};
    assign bus.rdata = rdata_q;
    assign bus.ack   = ack_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: one instance with WAIT=1, one with WAIT=0, each with a behavioural SRAM.
// Expected acks are queued at issue time and consumed by a negedge monitor.
module tb_sram_ctrl;

    localparam int W0 = 1;
    localparam int W1 = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        int          cyc;
        logic [7:0]  rd;
        logic [15:0] addr;
        int          we_lo;
        int          oe_lo;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   we_cnt[2];
    int   oe_cnt[2];

    sram_ctrl_if #(.AWID(16), .DWID(8)) bus0 ();
    sram_ctrl_if #(.AWID(16), .DWID(8)) bus1 ();

    wire [15:0] addr0;
    wire [15:0] addr1;
    wire [7:0]  data0;
    wire [7:0]  data1;
    wire        ce0, oe0, we0, ce1, oe1, we1;

    logic [7:0] mem0 [0:65535];
    logic [7:0] mem1 [0:65535];
    logic       pen0 = 1'b0;
    logic       pen1 = 1'b0;
    logic [7:0] pval0 = 8'h00;
    logic [7:0] pval1 = 8'h00;

    sram_ctrl #(.AWID(16), .DWID(8), .WAIT(W0)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0),
        .sram_addr(addr0), .sram_data(data0),
        .sram_ce_n(ce0), .sram_oe_n(oe0), .sram_we_n(we0)
    );

    sram_ctrl #(.AWID(16), .DWID(8), .WAIT(W1)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1),
        .sram_addr(addr1), .sram_data(data1),
        .sram_ce_n(ce1), .sram_oe_n(oe1), .sram_we_n(we1)
    );

    // SRAM models drive the bus on reads; pen*/pval* is a probe driver used to detect high-Z
    assign data0 = (!ce0 && !oe0) ? mem0[addr0] : 8'bz;
    assign data1 = (!ce1 && !oe1) ? mem1[addr1] : 8'bz;
    assign data0 = pen0 ? pval0 : 8'bz;
    assign data1 = pen1 ? pval1 : 8'bz;

    always @(posedge clk) begin
        if (!ce0 && !we0) mem0[addr0] <= data0;
        if (!ce1 && !we1) mem1[addr1] <= data1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic mon(input int u, input logic ack, input logic busy, input logic [7:0] rd,
                       input logic [15:0] a, input logic ce, input logic oe, input logic we);
        exp_t e;
        int   n;
        if (!we) we_cnt[u]++;
        if (!oe) oe_cnt[u]++;
        check($sformatf("u%0d_we_oe_overlap", u), 32'(!we && !oe), 32'd0);
        check($sformatf("u%0d_idle_strobes", u), 32'(busy ? 3'b111 : {ce, oe, we}), 32'd7);
        if (ack) begin
            check($sformatf("u%0d_busy_at_ack", u), 32'(busy), 32'd1);
            n = (u == 0) ? q0.size() : q1.size();
            if (n == 0) begin
                check($sformatf("u%0d_unexpected_ack", u), 32'(ack), 32'd0);
            end else begin
                if (u == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                check($sformatf("u%0d_ack_cycle", u), 32'(cyc), 32'(e.cyc));
                check($sformatf("u%0d_rdata", u), 32'(rd), 32'(e.rd));
                check($sformatf("u%0d_addr_hold", u), 32'(a), 32'(e.addr));
                check($sformatf("u%0d_we_low_cycles", u), 32'(we_cnt[u]), 32'(e.we_lo));
                check($sformatf("u%0d_oe_low_cycles", u), 32'(oe_cnt[u]), 32'(e.oe_lo));
            end
            we_cnt[u] = 0;
            oe_cnt[u] = 0;
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            we_cnt[0] = 0; oe_cnt[0] = 0; we_cnt[1] = 0; oe_cnt[1] = 0;
        end else begin
            mon(0, bus0.ack, bus0.busy, bus0.rdata, addr0, ce0, oe0, we0);
            mon(1, bus1.ack, bus1.busy, bus1.rdata, addr1, ce1, oe1, we1);
        end
    end

    task automatic drive_host(input int u, input logic r, input logic w,
                              input logic [15:0] a, input logic [7:0] d);
        if (u == 0) begin
            bus0.req = r; bus0.wr = w; bus0.addr = a; bus0.wdata = d;
        end else begin
            bus1.req = r; bus1.wr = w; bus1.addr = a; bus1.wdata = d;
        end
    endtask

    function automatic exp_t mk(input int u, input logic w, input logic [15:0] a, input logic [7:0] rd);
        exp_t e;
        int   lat;
        lat     = (u == 0) ? W0 : W1;
        e.cyc   = cyc + lat + 2;
        e.rd    = rd;
        e.addr  = a;
        e.we_lo = w ? lat + 1 : 0;
        e.oe_lo = w ? 0 : lat + 2;
        return e;
    endfunction

    task automatic wait_idle(input int u);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (((u == 0) ? bus0.busy : bus1.busy) == 1'b0) return;
        end
        check($sformatf("u%0d_idle_timeout", u), 32'd1, 32'd0);
    endtask

    // Called away from a clock edge; the next rising edge is the accept edge.
    task automatic access(input int u, input logic w, input logic [15:0] a,
                          input logic [7:0] d, input logic [7:0] exp_rd);
        drive_host(u, 1'b1, w, a, d);
        @(posedge clk);
        #1;
        if (u == 0) q0.push_back(mk(0, w, a, exp_rd));
        else        q1.push_back(mk(1, w, a, exp_rd));
        drive_host(u, 1'b0, 1'b0, 16'h0000, 8'h00);
        wait_idle(u);
    endtask

    task automatic zcheck(input int u, input string name);
        logic [7:0] v;
        for (int k = 0; k < 2; k++) begin
            v = (k == 0) ? 8'h00 : 8'hFF;
            if (u == 0) begin pen0 = 1'b1; pval0 = v; end
            else        begin pen1 = 1'b1; pval1 = v; end
            #1;
            check(name, 32'((u == 0) ? data0 : data1), 32'(v));
        end
        pen0 = 1'b0;
        pen1 = 1'b0;
    endtask

    task automatic reset_checks(input int u);
        check($sformatf("u%0d_rst_ack", u), 32'((u == 0) ? bus0.ack : bus1.ack), 32'd0);
        check($sformatf("u%0d_rst_busy", u), 32'((u == 0) ? bus0.busy : bus1.busy), 32'd0);
        check($sformatf("u%0d_rst_rdata", u), 32'((u == 0) ? bus0.rdata : bus1.rdata), 32'd0);
        check($sformatf("u%0d_rst_addr", u), 32'((u == 0) ? addr0 : addr1), 32'd0);
        check($sformatf("u%0d_rst_strobes", u),
              32'((u == 0) ? {ce0, oe0, we0} : {ce1, oe1, we1}), 32'd7);
        zcheck(u, $sformatf("u%0d_rst_data_z", u));
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem0[i] = 8'h00;
            mem1[i] = 8'h00;
        end
        mem0[16'h00FF] = 8'hC3;
        mem1[16'hFFFF] = 8'h81;
        drive_host(0, 1'b0, 1'b0, 16'h0000, 8'h00);
        drive_host(1, 1'b0, 1'b0, 16'h0000, 8'h00);

        // Asynchronous reset before any clock edge
        #1 rst_n = 1'b0;
        #1;
        reset_checks(0);
        reset_checks(1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // WAIT=1: write accepted on the first edge after reset release, then read back
        access(0, 1'b1, 16'h1234, 8'hA5, 8'h00);
        check("u0_mem_1234", 32'(mem0[16'h1234]), 32'h0000_00A5);
        zcheck(0, "u0_idle_data_z");
        access(0, 1'b0, 16'h1234, 8'h00, 8'hA5);
        access(0, 1'b1, 16'h1234, 8'h11, 8'hA5);
        check("u0_rdata_held", 32'(bus0.rdata), 32'h0000_00A5);
        access(0, 1'b0, 16'h00FF, 8'h00, 8'hC3);

        // WAIT=0: minimum timing, boundary addresses
        access(1, 1'b1, 16'h0000, 8'h3C, 8'h00);
        access(1, 1'b0, 16'h0000, 8'h00, 8'h3C);
        access(1, 1'b0, 16'hFFFF, 8'h00, 8'h81);
        access(1, 1'b1, 16'hFFFF, 8'h00, 8'h81);
        access(1, 1'b0, 16'hFFFF, 8'h00, 8'h00);

        // req held through a write: second accept one cycle after ack, no extra acks
        drive_host(0, 1'b1, 1'b1, 16'h0100, 8'h5E);
        @(posedge clk);
        #1;
        q0.push_back(mk(0, 1'b1, 16'h0100, 8'hC3));
        repeat (W0 + 4) @(posedge clk);
        #1;
        q0.push_back(mk(0, 1'b1, 16'h0100, 8'hC3));
        drive_host(0, 1'b0, 1'b0, 16'h0000, 8'h00);
        wait_idle(0);
        repeat (3) @(negedge clk);
        check("u0_mem_0100", 32'(mem0[16'h0100]), 32'h0000_005E);
        check("u0_held_acks_drained", 32'(q0.size()), 32'd0);

        // Reset during the ACCESS phase of a write aborts it without a clock edge
        drive_host(0, 1'b1, 1'b1, 16'h0042, 8'h77);
        @(posedge clk);
        #1;
        drive_host(0, 1'b0, 1'b0, 16'h0000, 8'h00);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("u0_abort_strobes", 32'({ce0, oe0, we0}), 32'd7);
        check("u0_abort_busy", 32'(bus0.busy), 32'd0);
        check("u0_abort_ack", 32'(bus0.ack), 32'd0);
        zcheck(0, "u0_abort_data_z");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("u0_mem_0042", 32'(mem0[16'h0042]), 32'd0);
        access(0, 1'b0, 16'h1234, 8'h00, 8'h11);

        for (int i = 0; i < 20 && (q0.size() + q1.size()) != 0; i++) @(negedge clk);
        check("pending_acks", 32'(q0.size() + q1.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
